// File: rtl/fft_4p_input_buffer.sv
// -----------------------------------------------------------------------------
// fft_4p_input_buffer
//
// Ping-pong input reorder buffer for the 4-point FFT datapath. Complex samples
// arrive one per cycle over a valid/ready stream. Each group of four is stored
// in bit-reversed slot order, so a completed frame is presented in parallel as
// out_0=x0, out_1=x2, out_2=x1, out_3=x3. This puts the pairs (x0,x2) and
// (x1,x3) on adjacent butterfly inputs. Two banks let one frame fill while the
// other drains.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  input stream handshake
//   in_sof               start of frame, forces the sample to slot x0
//   in_real, in_imag     input sample (signed, passed through bit-exact)
//   out_valid/out_ready  frame handshake; frame consumed when both high
//   out_N_real/imag      frame words in bit-reversed order
//   sof_err              one-cycle pulse, a partial frame was discarded
// -----------------------------------------------------------------------------
module fft_4p_input_buffer #(
   parameter int DATAWIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sof,
   input  logic [DATAWIDTH-1:0] in_real,
   input  logic [DATAWIDTH-1:0] in_imag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] out_0_real,
   output logic [DATAWIDTH-1:0] out_0_imag,
   output logic [DATAWIDTH-1:0] out_1_real,
   output logic [DATAWIDTH-1:0] out_1_imag,
   output logic [DATAWIDTH-1:0] out_2_real,
   output logic [DATAWIDTH-1:0] out_2_imag,
   output logic [DATAWIDTH-1:0] out_3_real,
   output logic [DATAWIDTH-1:0] out_3_imag,
   output logic                 sof_err
);

   typedef enum logic {BANK_A = 1'b0, BANK_B = 1'b1} bank_e;

   typedef struct packed {
      logic [DATAWIDTH-1:0] re;
      logic [DATAWIDTH-1:0] im;
   } sample_t;

   sample_t    bank_q [2][4];
   sample_t    bank_d [2][4];
   bank_e      wr_bank_q, wr_bank_d;
   bank_e      rd_bank_q, rd_bank_d;
   logic [1:0] wr_idx_q,  wr_idx_d;
   logic [1:0] full_q,    full_d;
   logic       sof_err_q, sof_err_d;

   logic       accept;
   logic       consume;
   logic [1:0] wr_slot;

   function automatic logic [1:0] bitrev2(input logic [1:0] idx);
      return {idx[0], idx[1]};
   endfunction

   // Holding rst low in in_ready keeps upstream from handing over a sample
   // that the reset would silently drop.
   assign in_ready = !full_q[wr_bank_q] && !rst;
   assign accept   = in_valid && in_ready;
   // Both banks empty means full_q[rd_bank_q] is low, so no read can occur.
   assign consume  = full_q[rd_bank_q] && out_ready;

   // NOTE: every variable is given its default first, so no path through this
   // block leaves a value unassigned and no latch is inferred.
   always_comb begin
      bank_d    = bank_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_idx_d  = wr_idx_q;
      full_d    = full_q;
      sof_err_d = 1'b0;
      wr_slot   = bitrev2(wr_idx_q);

      if (accept) begin
         if (in_sof) begin
            // A start-of-frame always restarts the frame in the same bank;
            // any partially written samples are simply overwritten later.
            wr_slot   = 2'd0;
            wr_idx_d  = 2'd1;
            sof_err_d = (wr_idx_q != 2'd0);
         end else begin
            wr_idx_d = wr_idx_q + 2'd1;
            if (wr_idx_q == 2'd3) begin
               full_d[wr_bank_q] = 1'b1;
               wr_bank_d         = bank_e'(~wr_bank_q);
            end
         end
         bank_d[wr_bank_q][wr_slot] = '{re: in_real, im: in_imag};
      end

      // The write side only targets a non-full bank, so this never collides
      // with a same-cycle frame completion on the other bank.
      if (consume) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = bank_e'(~rd_bank_q);
      end
   end

   // NOTE: the bank storage is reset along with the control state because
   // the frame outputs must read as zero after reset, not as stale data.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank_q <= BANK_A;
         rd_bank_q <= BANK_A;
         wr_idx_q  <= '0;
         full_q    <= '0;
         sof_err_q <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < 4; s++) begin
               bank_q[b][s] <= '0;
            end
         end
      end else begin
         // NOTE: state updates use non-blocking assignments so every register
         // samples the pre-edge values regardless of statement order.
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_idx_q  <= wr_idx_d;
         full_q    <= full_d;
         sof_err_q <= sof_err_d;
         bank_q    <= bank_d;
      end
   end

   assign out_valid  = full_q[rd_bank_q];
   assign sof_err    = sof_err_q;
   assign out_0_real = bank_q[rd_bank_q][0].re;
   assign out_0_imag = bank_q[rd_bank_q][0].im;
   assign out_1_real = bank_q[rd_bank_q][1].re;
   assign out_1_imag = bank_q[rd_bank_q][1].im;
   assign out_2_real = bank_q[rd_bank_q][2].re;
   assign out_2_imag = bank_q[rd_bank_q][2].im;
   assign out_3_real = bank_q[rd_bank_q][3].re;
   assign out_3_imag = bank_q[rd_bank_q][3].im;

endmodule

// File: doc/fft_4p_input_buffer.md
# fft_4p_input_buffer

Ping-pong input reorder buffer for the 4-point FFT datapath. It accepts one complex sample per cycle over a valid/ready stream and collects four samples per frame. Each completed frame is presented in parallel and in bit-reversed order to the first butterfly rank, so the pairs (x0,x2) and (x1,x3) land on adjacent butterfly inputs. Two banks let one frame be filled while the previous one drains.

## Interface

Parameters:
- DATAWIDTH, 16, width of each real and imaginary component, signed two's complement, passed through unmodified.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  buffer can accept a sample this cycle.
- in_sof  in  1  start of frame; qualified by in_valid, marks sample x0.
- in_real, in_imag  in  DATAWIDTH each  input sample, signed.
- out_valid  out  1  a full frame is presented on out_*.
- out_ready  in  1  downstream consumes the frame this cycle.
- out_0_real/imag … out_3_real/imag  out  DATAWIDTH each  frame in bit-reversed order: out_0=x0, out_1=x2, out_2=x1, out_3=x3.
- sof_err  out  1  one-cycle pulse: a partial frame was discarded.

## Operation

- Storage: two banks (A, B), each holding 4 complex words. Each bank has a full flag.
- Write pointer wr_bank and 2-bit sample index wr_idx. Read pointer rd_bank.
- Accept condition: in_valid && in_ready.
- in_ready = !full[wr_bank] && !rst.
- On accept, the sample is written to bank[wr_bank], slot bitrev(wr_idx): 0→0, 1→2, 2→1, 3→3.
- Then wr_idx increments. If wr_idx was 3, full[wr_bank] is set, wr_idx goes to 0 and wr_bank toggles.
- in_sof:
  - An accepted sample with in_sof=1 is always written as x0. wr_idx becomes 1.
  - If wr_idx was nonzero at that point, the partial frame is discarded. sof_err pulses on the next cycle. The write bank does not toggle.
  - in_sof=0 with wr_idx=0 is accepted as x0. There is no error in this case, so headerless streaming is allowed.
- Output side:
  - out_valid = full[rd_bank].
  - out_* drive bank[rd_bank] directly (registered storage, no combinational path from in_*).
  - Frame consumed when out_valid && out_ready: clears full[rd_bank] and toggles rd_bank.
- Simultaneous events:
  - A frame completion on the write side and a consume on the read side in the same cycle are both applied.
  - Write and read always target different banks, except when both banks are empty. In that case no read occurs.
  - A consume frees its bank for writes starting on the next cycle; there is no same-cycle bypass.
- No arithmetic; data widths are preserved bit-exact.

## Timing

- Reset values (rst high at a clock edge):
  - wr_idx=0, wr_bank=A, rd_bank=A, full[A]=full[B]=0.
  - out_valid=0, sof_err=0, all out_* data=0 (banks cleared).
  - in_ready=0 while rst is high and 1 on the first cycle after.
- Reset during a frame drops all stored and partial data, with no sof_err pulse.
- Latency: out_valid rises 1 cycle after the edge that accepts the 4th sample.
- Throughput: 1 sample/cycle sustained, i.e. 1 frame per 4 cycles, when out_ready stays high.
- Backpressure: in_ready falls only when both banks are full. It rises 1 cycle after the consume that frees a bank.
- out_* data stays stable while out_valid=1 and out_ready=0.
- sof_err is high for exactly one cycle, the one following the accept that discarded the partial frame.

## Test plan

- Reset, then stream samples real=1..4, imag=-1..-4 with out_ready=1.
  - out_valid on the cycle after the 4th accept.
  - out_0..3 real = 1,3,2,4; imag = -1,-3,-2,-4.
  - Consumed in 1 cycle.
- Continuous stream of 12 samples with out_ready=1: in_ready stays 1 throughout, and three frames emerge back-to-back 4 cycles apart.
- out_ready=0, stream 8 samples, then offer a 9th:
  - in_ready=0 after the 8th accept.
  - Frame A is held stable.
  - Raising out_ready for 1 cycle returns in_ready=1 on the next cycle, and frame B is then presented.
- Send 2 samples, then a sample with in_sof=1 plus 3 more:
  - sof_err pulses once.
  - The output frame is the sof sample and the 3 following ones; the first 2 are discarded.
- Assert rst after 2 samples of a frame while the other bank is full:
  - out_valid=0 and in_ready=0 during reset.
  - After reset, a fresh 4-sample frame emerges alone, with no sof_err.
- In the same cycle, a 4th-sample accept into B and a consume of A:
  - Both full flags update correctly.
  - out_valid stays 1 and now presents B.
